// File: rtl/axi_line_master.sv
// axi_line_master: turns single cache-line requests into AXI bursts.
//   Refill (io_req_wr=0): AR then R beats, line returned on io_resp_rdata.
//   Writeback (io_req_wr=1): AW, W beats, then waits for B.
// Ports:
//   clock, reset (async active-low)
//   io_req_*  : line request handshake (valid/ready, wr, addr, wdata)
//   io_resp_* : one-cycle completion pulse with refill line and error flag
//   io_axi_bus_{ar,r,aw,w,b}_* : AXI master channels (R and B have no ready)
module axi_line_master #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned BEATS  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_req_valid,
    output logic                  io_req_ready,
    input  logic                  io_req_wr,
    input  logic [ADDR_W-1:0]     io_req_addr,
    input  logic [64*BEATS-1:0]   io_req_wdata,
    output logic                  io_resp_valid,
    output logic [64*BEATS-1:0]   io_resp_rdata,
    output logic                  io_resp_err,
    output logic                  io_axi_bus_ar_valid,
    input  logic                  io_axi_bus_ar_ready,
    output logic [ADDR_W-1:0]     io_axi_bus_ar_bits_araddr,
    output logic [7:0]            io_axi_bus_ar_bits_arlen,
    input  logic                  io_axi_bus_r_valid,
    input  logic [63:0]           io_axi_bus_r_bits_rdata,
    input  logic                  io_axi_bus_r_bits_rlast,
    output logic                  io_axi_bus_aw_valid,
    input  logic                  io_axi_bus_aw_ready,
    output logic [ADDR_W-1:0]     io_axi_bus_aw_bits_awaddr,
    output logic                  io_axi_bus_w_valid,
    input  logic                  io_axi_bus_w_ready,
    output logic [63:0]           io_axi_bus_w_bits_wdata,
    output logic [7:0]            io_axi_bus_w_bits_wstrb,
    output logic                  io_axi_bus_w_bits_wlast,
    input  logic                  io_axi_bus_b_valid
);

    localparam int unsigned LINE_W = 64 * BEATS;
    localparam int unsigned CW     = $clog2(BEATS) + 1;
    localparam int unsigned IW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W  = $clog2(8 * BEATS);

    localparam logic [CW-1:0]     CNT_LAST  = CW'(BEATS - 1);
    localparam logic [CW-1:0]     CNT_FULL  = CW'(BEATS);
    localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFF_W;

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_RESP
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic                   beat_in_range;
    logic [ADDR_W-1:0]      addr_q;
    logic [BEATS-1:0][63:0] wline_q;
    logic [BEATS-1:0][63:0] rbuf_q;
    logic [BEATS-1:0][63:0] rbuf_nx;
    logic [LINE_W-1:0]      rdata_q;
    logic                   err_q;
    logic                   accept;

    assign accept        = (state == S_IDLE) && io_req_valid;
    assign idx           = IW'(cnt);
    assign beat_in_range = (cnt < CNT_FULL);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (io_req_valid) state_nx = io_req_wr ? S_AW : S_AR;
            S_AR:   if (io_axi_bus_ar_ready) state_nx = S_R;
            S_R:    if (io_axi_bus_r_valid && io_axi_bus_r_bits_rlast) state_nx = S_RESP;
            S_AW:   if (io_axi_bus_aw_ready) state_nx = S_W;
            S_W:    if (io_axi_bus_w_ready && (cnt == CNT_LAST)) state_nx = S_B;
            S_B:    if (io_axi_bus_b_valid) state_nx = S_RESP;
            S_RESP: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state register or taken from flops only
    always_comb begin
        io_req_ready              = 1'b0;
        io_resp_valid             = 1'b0;
        io_axi_bus_ar_valid       = 1'b0;
        io_axi_bus_aw_valid       = 1'b0;
        io_axi_bus_w_valid        = 1'b0;
        io_axi_bus_w_bits_wlast   = 1'b0;
        io_axi_bus_ar_bits_araddr = addr_q;
        io_axi_bus_aw_bits_awaddr = addr_q;
        io_axi_bus_ar_bits_arlen  = 8'(BEATS - 1);
        io_axi_bus_w_bits_wdata   = wline_q[idx];
        io_axi_bus_w_bits_wstrb   = 8'hFF;
        io_resp_rdata             = rdata_q;
        io_resp_err               = err_q;
        case (state)
            S_IDLE: io_req_ready        = 1'b1;
            S_AR:   io_axi_bus_ar_valid = 1'b1;
            S_AW:   io_axi_bus_aw_valid = 1'b1;
            S_W: begin
                io_axi_bus_w_valid      = 1'b1;
                io_axi_bus_w_bits_wlast = (cnt == CNT_LAST);
            end
            S_RESP: io_resp_valid       = 1'b1;
            default: ;
        endcase
    end

    // Refill buffer with the current R beat merged in (out-of-range beats dropped)
    always_comb begin
        rbuf_nx = rbuf_q;
        if (beat_in_range) rbuf_nx[idx] = io_axi_bus_r_bits_rdata;
    end

    // Datapath: request latch, beat counter, refill assembly, error flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                cnt     <= '0;
                addr_q  <= io_req_addr & ADDR_MASK;
                wline_q <= io_req_wdata;
                rbuf_q  <= '0;
                err_q   <= 1'b0;
            end
            if ((state == S_R) && io_axi_bus_r_valid) begin
                rbuf_q <= rbuf_nx;
                // Saturate so a long burst can never wrap back into a valid slot
                if (cnt != CNT_FULL) cnt <= cnt + CW'(1);
                if (!beat_in_range || (io_axi_bus_r_bits_rlast && (cnt != CNT_LAST))) begin
                    err_q <= 1'b1;
                end
                // Visible line only changes when a refill completes
                if (io_axi_bus_r_bits_rlast) rdata_q <= rbuf_nx;
            end
            if ((state == S_W) && io_axi_bus_w_ready) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_axi_line_master.sv
// Self-checking bench for axi_line_master: directed scenarios plus randomized
// refill/writeback traffic compared against a line-level reference model.
module tb_axi_line_master;

    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned BEATS      = 2;
    localparam int unsigned LINE_W     = 64 * BEATS;
    localparam longint unsigned LINE_BYTES = 8 * BEATS;

    logic                clock;
    logic                reset;
    logic                io_req_valid;
    logic                io_req_ready;
    logic                io_req_wr;
    logic [ADDR_W-1:0]   io_req_addr;
    logic [LINE_W-1:0]   io_req_wdata;
    logic                io_resp_valid;
    logic [LINE_W-1:0]   io_resp_rdata;
    logic                io_resp_err;
    logic                ar_valid, ar_ready;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic                r_valid, r_rlast;
    logic [63:0]         r_rdata;
    logic                aw_valid, aw_ready;
    logic [ADDR_W-1:0]   awaddr;
    logic                w_valid, w_ready, w_wlast;
    logic [63:0]         w_wdata;
    logic [7:0]          w_wstrb;
    logic                b_valid;

    int checks = 0;
    int errors = 0;

    logic [63:0]       rbeats[$];
    logic [LINE_W-1:0] exp_rline;

    axi_line_master #(.ADDR_W(ADDR_W), .BEATS(BEATS)) dut (
        .clock                     (clock),
        .reset                     (reset),
        .io_req_valid              (io_req_valid),
        .io_req_ready              (io_req_ready),
        .io_req_wr                 (io_req_wr),
        .io_req_addr               (io_req_addr),
        .io_req_wdata              (io_req_wdata),
        .io_resp_valid             (io_resp_valid),
        .io_resp_rdata             (io_resp_rdata),
        .io_resp_err               (io_resp_err),
        .io_axi_bus_ar_valid       (ar_valid),
        .io_axi_bus_ar_ready       (ar_ready),
        .io_axi_bus_ar_bits_araddr (araddr),
        .io_axi_bus_ar_bits_arlen  (arlen),
        .io_axi_bus_r_valid        (r_valid),
        .io_axi_bus_r_bits_rdata   (r_rdata),
        .io_axi_bus_r_bits_rlast   (r_rlast),
        .io_axi_bus_aw_valid       (aw_valid),
        .io_axi_bus_aw_ready       (aw_ready),
        .io_axi_bus_aw_bits_awaddr (awaddr),
        .io_axi_bus_w_valid        (w_valid),
        .io_axi_bus_w_ready        (w_ready),
        .io_axi_bus_w_bits_wdata   (w_wdata),
        .io_axi_bus_w_bits_wstrb   (w_wstrb),
        .io_axi_bus_w_bits_wlast   (w_wlast),
        .io_axi_bus_b_valid        (b_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [LINE_W-1:0] got,
                         input logic [LINE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
        return a - (a % LINE_BYTES);
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // No AXI master valid other than the allowed one may be high
    task automatic check_idle_channels(input string tag);
        check({tag, " ar_valid"}, ar_valid, 1'b0);
        check({tag, " aw_valid"}, aw_valid, 1'b0);
        check({tag, " w_valid"},  w_valid,  1'b0);
    endtask

    // Refill using beats queued in rbeats; nbeats may differ from BEATS
    task automatic do_refill(input logic [ADDR_W-1:0] addr, input int ar_wait,
                             input int max_gap, input bit hold);
        int n;
        logic [LINE_W-1:0] line;
        logic              exp_err;
        n = rbeats.size();
        line = '0;
        for (int k = 0; k < BEATS; k++)
            if (k < n) line[64*k +: 64] = rbeats[k];
        exp_err = (n != BEATS);

        io_req_valid = 1'b1;
        io_req_wr    = 1'b0;
        io_req_addr  = addr;
        check("rf req_ready", io_req_ready, 1'b1);
        @(negedge clock);
        if (!hold) io_req_valid = 1'b0;
        check("rf ar_valid", ar_valid, 1'b1);
        check("rf araddr", araddr, line_base(addr));
        check("rf arlen", arlen, 8'(BEATS - 1));
        check("rf req_ready busy", io_req_ready, 1'b0);
        for (int i = 0; i < ar_wait; i++) begin
            @(negedge clock);
            check("rf ar_valid held", ar_valid, 1'b1);
            check("rf araddr held", araddr, line_base(addr));
        end
        ar_ready = 1'b1;
        @(negedge clock);
        ar_ready = 1'b0;
        check_idle_channels("rf in R");
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                @(negedge clock);
                check("rf gap resp_valid", io_resp_valid, 1'b0);
            end
            r_valid = 1'b1;
            r_rdata = rbeats[i];
            r_rlast = (i == n - 1);
            @(negedge clock);
            r_valid = 1'b0;
            r_rlast = 1'b0;
            if (i != n - 1) check("rf early resp", io_resp_valid, 1'b0);
        end
        check("rf resp_valid", io_resp_valid, 1'b1);
        check("rf resp_rdata", io_resp_rdata, line);
        check("rf resp_err", io_resp_err, exp_err);
        check("rf ready in resp", io_req_ready, 1'b0);
        exp_rline = line;
        @(negedge clock);
        check("rf resp pulse end", io_resp_valid, 1'b0);
        check("rf ready after", io_req_ready, 1'b1);
        check("rf rdata held", io_resp_rdata, exp_rline);
    endtask

    task automatic do_writeback(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] line,
                                input int aw_wait, input int w_lo, input int w_hi,
                                input int b_wait);
        io_req_valid = 1'b1;
        io_req_wr    = 1'b1;
        io_req_addr  = addr;
        io_req_wdata = line;
        check("wb req_ready", io_req_ready, 1'b1);
        @(negedge clock);
        io_req_valid = 1'b0;
        check("wb aw_valid", aw_valid, 1'b1);
        check("wb awaddr", awaddr, line_base(addr));
        check("wb ar_valid", ar_valid, 1'b0);
        for (int i = 0; i < aw_wait; i++) begin
            @(negedge clock);
            check("wb aw_valid held", aw_valid, 1'b1);
        end
        aw_ready = 1'b1;
        @(negedge clock);
        aw_ready = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            int ww;
            ww = int'($urandom_range(w_hi, w_lo));
            for (int i = 0; i <= ww; i++) begin
                check("wb w_valid", w_valid, 1'b1);
                check("wb wdata", w_wdata, line[64*k +: 64]);
                check("wb wstrb", w_wstrb, 8'hFF);
                check("wb wlast", w_wlast, (k == BEATS - 1));
                check("wb aw_valid off", aw_valid, 1'b0);
                if (i == ww) w_ready = 1'b1;
                @(negedge clock);
                w_ready = 1'b0;
            end
        end
        check_idle_channels("wb in B");
        check("wb wlast off", w_wlast, 1'b0);
        for (int i = 0; i < b_wait; i++) begin
            @(negedge clock);
            check("wb wait resp_valid", io_resp_valid, 1'b0);
        end
        b_valid = 1'b1;
        @(negedge clock);
        b_valid = 1'b0;
        check("wb resp_valid", io_resp_valid, 1'b1);
        check("wb resp_err", io_resp_err, 1'b0);
        @(negedge clock);
        check("wb resp pulse end", io_resp_valid, 1'b0);
    endtask

    initial begin
        reset        = 1'b0;
        io_req_valid = 1'b0;
        io_req_wr    = 1'b0;
        io_req_addr  = '0;
        io_req_wdata = '0;
        ar_ready     = 1'b0;
        r_valid      = 1'b0;
        r_rdata      = '0;
        r_rlast      = 1'b0;
        aw_ready     = 1'b0;
        w_ready      = 1'b0;
        b_valid      = 1'b0;
        exp_rline    = '0;

        // Reset state
        #1;
        check("rst req_ready", io_req_ready, 1'b1);
        check("rst resp_valid", io_resp_valid, 1'b0);
        check("rst resp_rdata", io_resp_rdata, '0);
        check("rst resp_err", io_resp_err, 1'b0);
        check("rst wlast", w_wlast, 1'b0);
        check_idle_channels("rst");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Directed refill: zero-wait responder
        rbeats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
        do_refill(64'h8000_001C, 0, 0, 1'b0);

        // Directed writeback with W stalls of three cycles per beat
        do_writeback(64'h8000_0020, {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                     0, 3, 3, 2);

        // Short burst and over-long burst both flag an error
        rbeats = '{64'h3333_3333_3333_3333};
        do_refill(64'h0000_0040, 1, 0, 1'b0);
        rbeats = '{64'h4444_4444_4444_4444, 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666};
        do_refill(64'h0000_0080, 0, 1, 1'b0);

        // Spurious R/B in IDLE
        r_valid = 1'b1; r_rlast = 1'b1; r_rdata = 64'hDEAD_BEEF_DEAD_BEEF; b_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("spur resp_valid", io_resp_valid, 1'b0);
            check("spur req_ready", io_req_ready, 1'b1);
            check("spur rdata", io_resp_rdata, exp_rline);
            check_idle_channels("spur");
        end
        r_valid = 1'b0; r_rlast = 1'b0; b_valid = 1'b0;
        @(negedge clock);

        // Back-to-back: request held valid; second accepted the cycle after resp
        rbeats = '{rnd64(), rnd64()};
        do_refill(64'h0000_1000, 0, 0, 1'b1);
        check("b2b req_valid held", io_req_valid, 1'b1);
        do_writeback(64'h0000_2008, {rnd64(), rnd64()}, 0, 0, 0, 0);

        // Async reset during W beat 0, then a clean refill
        io_req_valid = 1'b1; io_req_wr = 1'b1; io_req_addr = 64'h0000_3000;
        io_req_wdata = {rnd64(), rnd64()};
        @(negedge clock);
        io_req_valid = 1'b0;
        aw_ready = 1'b1;
        @(negedge clock);
        aw_ready = 1'b0;
        check("rstmid w_valid before", w_valid, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("rstmid w_valid", w_valid, 1'b0);
        check("rstmid wlast", w_wlast, 1'b0);
        check("rstmid req_ready", io_req_ready, 1'b1);
        check("rstmid resp_rdata", io_resp_rdata, '0);
        check("rstmid resp_valid", io_resp_valid, 1'b0);
        exp_rline = '0;
        @(negedge clock);
        reset = 1'b1;
        check("rstmid ready after", io_req_ready, 1'b1);
        rbeats = '{rnd64(), rnd64()};
        do_refill(64'h0000_4018, 0, 0, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 30; t++) begin
            logic [ADDR_W-1:0] a;
            a = rnd64();
            if ($urandom_range(1, 0) == 1) begin
                do_writeback(a, {rnd64(), rnd64()}, int'($urandom_range(2, 0)),
                             0, 3, int'($urandom_range(3, 0)));
            end else begin
                int nb;
                nb = ($urandom_range(3, 0) == 0) ? int'($urandom_range(BEATS + 1, 1)) : BEATS;
                rbeats.delete();
                for (int k = 0; k < nb; k++) rbeats.push_back(rnd64());
                do_refill(a, int'($urandom_range(2, 0)), 2, 1'b0);
            end
            repeat ($urandom_range(2, 0)) begin
                @(negedge clock);
                check("rand idle resp_valid", io_resp_valid, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_line_master.md
AXI_LINE_MASTER -- requirements
Module: axi_line_master

Interface
REQ-001 Parameter ADDR_W, 64, width of request and AXI addresses.
REQ-002 Parameter BEATS, 2, 64-bit beats per cache line (line = 64*BEATS bits).
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-005 io_req_valid / io_req_ready  in / out  1 / 1  line request handshake.
REQ-006 io_req_wr  in  1  1 = line writeback, 0 = line refill.
REQ-007 io_req_addr  in  ADDR_W  line address; low log2(8*BEATS) bits ignored.
REQ-008 io_req_wdata  in  64*BEATS  writeback line; beat k = bits [64k+63:64k].
REQ-009 io_resp_valid  out  1  one-cycle completion pulse.
REQ-010 io_resp_rdata  out  64*BEATS  refill line, valid while io_resp_valid=1.
REQ-011 io_resp_err  out  1  burst-length mismatch flag, valid with io_resp_valid.
REQ-012 io_axi_bus_ar_valid/_ar_ready  out/in  1/1; ar_bits_araddr  out  ADDR_W; ar_bits_arlen  out  8.
REQ-013 io_axi_bus_r_valid  in  1; r_bits_rdata  in  64; r_bits_rlast  in  1.
REQ-014 io_axi_bus_aw_valid/_aw_ready  out/in  1/1; aw_bits_awaddr  out  ADDR_W.
REQ-015 io_axi_bus_w_valid/_w_ready  out/in  1/1; w_bits_wdata  out  64; w_bits_wstrb  out  8; w_bits_wlast  out  1.
REQ-016 io_axi_bus_b_valid  in  1.

Function
REQ-017 The block SHALL be an FSM with states IDLE, AR, R, AW, W, B, RESP.
REQ-018 io_req_ready SHALL be 1 only in IDLE; acceptance (valid&ready) SHALL latch addr (low bits zeroed), wr, wdata, and go to AR (wr=0) or AW (wr=1).
REQ-019 AR: ar_valid=1, araddr=latched addr, arlen=BEATS-1, all held stable; ar_valid&ar_ready -> R next cycle.
REQ-020 R: every cycle with r_valid=1 SHALL store rdata into beat slot cnt and increment cnt; r has no ready, so every beat SHALL be accepted.
REQ-021 R: r_valid&rlast -> RESP; io_resp_err=1 if that beat index != BEATS-1.
REQ-022 R: beats with index >= BEATS SHALL be discarded (no slot write), err set, state held until rlast.
REQ-023 AW: aw_valid=1, awaddr=latched addr, stable until aw_valid&aw_ready -> W.
REQ-024 W: w_valid=1, wdata=beat cnt, wstrb=8'hFF, wlast=(cnt==BEATS-1); beat advances only on w_valid&w_ready.
REQ-025 W: handshake of wlast beat -> B; w_valid SHALL drop the next cycle.
REQ-026 B: b_valid=1 -> RESP; io_resp_err=0 for writes.
REQ-027 RESP: io_resp_valid=1 exactly one cycle, then IDLE; io_resp_rdata holds refill line until next refill completes (undefined content for writes not required).
REQ-028 r_valid outside R and b_valid outside B SHALL be ignored with no state change.
REQ-029 Only one of ar_valid, aw_valid, w_valid SHALL be 1 in any cycle; none in IDLE/B/RESP.
REQ-030 Beat counter SHALL clear on every request acceptance; width ceil(log2(BEATS))+1 so it cannot wrap inside one burst.
REQ-031 Back-to-back requests: new request accepted no earlier than the cycle after RESP (IDLE), giving min refill latency 4 cycles accept-to-resp with BEATS=2 and zero-wait responder.

Reset
REQ-032 reset=0 SHALL asynchronously force IDLE, cnt=0, all valid outputs 0, io_resp_err=0, io_resp_rdata=0, wlast=0.
REQ-033 Reset mid-burst SHALL abandon the transaction with no completion pulse; after release io_req_ready=1 in the first clock edge's cycle.
REQ-034 Outputs SHALL be glitch-free registered or state-decoded values; no combinational path from any AXI input to any AXI valid output.

Verification
REQ-035 Refill addr 0x8000_001C, zero-wait RAM, beats 0x11..,0x22.. -> araddr 0x8000_0010, arlen 1, resp_rdata {0x22..,0x11..}, err 0.
REQ-036 Writeback addr 0x8000_0020, wdata {B,A}, w_ready low 3 cycles -> A then B each held stable, wstrb FF, wlast only on B, single resp pulse after b_valid.
REQ-037 Refill with rlast on first beat -> RESP after 1 beat, err=1; with 3 beats (rlast on 3rd) -> third discarded, err=1.
REQ-038 Spurious b_valid/r_valid in IDLE -> no state change, no resp pulse.
REQ-039 reset=0 asynchronously during W beat 0 -> w_valid drops without clock edge; after release, new refill completes normally.
REQ-040 Two back-to-back requests held valid -> second accepted exactly one cycle after first io_resp_valid.
